// File: rtl/swipt_pll_seq.sv
// PLL sequencer for the SWIPT receive path: presets the PLL frequency, switches
// loop gain between acquisition and tracking, and tracks lock from phase error.
module swipt_pll_seq #(
  parameter int                FREQ_W       = 32,
  parameter int                ERR_W        = 16,
  parameter int                LG_W         = 5,
  parameter int                LG_ACQ       = 11,
  parameter int                LG_TRK       = 13,
  parameter int                LOCK_WIN     = 64,
  parameter int                LOCK_CNT     = 8,
  parameter int                UNLOCK_CNT   = 4,
  parameter int                LOAD_CYC     = 16,
  parameter int                ACQ_TIMEOUT  = 100000,
  parameter logic [FREQ_W-1:0] DEFAULT_FREQ = 32'h9C40
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              swiptAlive,
  input  logic              adc_comp,
  input  logic [FREQ_W-1:0] freq_cfg,
  input  logic              err_valid,
  input  logic [ERR_W-1:0]  err,
  output logic [FREQ_W-1:0] freq,
  output logic              load_freq,
  output logic [LG_W-1:0]   lgcoefficient,
  output logic              pll_in,
  output logic              locked,
  output logic [1:0]        state,
  output logic [7:0]        reacq_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_ACQ    = 2'd2;
  localparam logic [1:0] S_LOCKED = 2'd3;

  localparam int CYC_MAX = (ACQ_TIMEOUT > LOAD_CYC) ? ACQ_TIMEOUT : LOAD_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int GOOD_W  = $clog2(LOCK_CNT + 1);
  localparam int BAD_W   = $clog2(UNLOCK_CNT + 1);

  logic [1:0]        r_state;
  logic [FREQ_W-1:0] r_freq;
  logic              r_load_freq;
  logic [LG_W-1:0]   r_lg;
  logic              r_pll_in;
  logic              r_locked;
  logic [7:0]        r_reacq;
  logic [CYC_W-1:0]  r_cyc;
  logic [GOOD_W-1:0] r_good;
  logic [BAD_W-1:0]  r_bad;

  logic signed [31:0] w_err_ext;
  logic               w_in_win;
  logic               w_good_hit;
  logic               w_bad_hit;
  logic               w_load_done;
  logic               w_timeout;
  logic [1:0]         w_nxt;
  logic               w_capture;
  logic               w_reacq_inc;
  logic               w_entry;

  // Signed compare on a widened copy, so the most negative sample simply falls outside.
  assign w_err_ext   = 32'(signed'(err));
  assign w_in_win    = (w_err_ext >= -LOCK_WIN) && (w_err_ext <= LOCK_WIN);
  assign w_good_hit  = err_valid && w_in_win && ((r_good + GOOD_W'(1)) == GOOD_W'(LOCK_CNT));
  assign w_bad_hit   = err_valid && !w_in_win && ((r_bad + BAD_W'(1)) == BAD_W'(UNLOCK_CNT));
  assign w_load_done = (r_cyc == CYC_W'(LOAD_CYC - 1));
  assign w_timeout   = (r_cyc == CYC_W'(ACQ_TIMEOUT - 1));

  always_comb begin
    w_nxt       = r_state;
    w_capture   = 1'b0;
    w_reacq_inc = 1'b0;
    if (!swiptAlive) begin
      w_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_nxt     = S_LOAD;
          w_capture = 1'b1;
        end
        S_LOAD: if (w_load_done) w_nxt = S_ACQ;
        S_ACQ: begin
          // Lock takes precedence over a coincident timeout.
          if (w_good_hit) begin
            w_nxt = S_LOCKED;
          end else if (w_timeout) begin
            w_nxt       = S_LOAD;
            w_capture   = 1'b1;
            w_reacq_inc = 1'b1;
          end
        end
        default: begin
          if (w_bad_hit) begin
            w_nxt       = S_ACQ;
            w_reacq_inc = 1'b1;
          end
        end
      endcase
    end
  end

  assign w_entry = (w_nxt != r_state);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state     <= S_IDLE;
      r_freq      <= DEFAULT_FREQ;
      r_load_freq <= 1'b1;
      r_lg        <= LG_W'(LG_ACQ);
      r_pll_in    <= 1'b0;
      r_locked    <= 1'b0;
      r_reacq     <= 8'd0;
      r_cyc       <= '0;
      r_good      <= '0;
      r_bad       <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_capture) r_freq <= freq_cfg;
      if (w_reacq_inc && (r_reacq != 8'hFF)) r_reacq <= r_reacq + 8'd1;
      if (w_entry) begin
        r_cyc  <= '0;
        r_good <= '0;
        r_bad  <= '0;
      end else begin
        if ((r_state == S_LOAD) || (r_state == S_ACQ)) r_cyc <= r_cyc + CYC_W'(1);
        if ((r_state == S_ACQ) && err_valid)
          r_good <= w_in_win ? r_good + GOOD_W'(1) : '0;
        if ((r_state == S_LOCKED) && err_valid)
          r_bad <= w_in_win ? '0 : r_bad + BAD_W'(1);
      end
      // Outputs decode the next state so they move on the same edge as state.
      r_load_freq <= (w_nxt == S_IDLE) || (w_nxt == S_LOAD);
      r_lg        <= (w_nxt == S_LOCKED) ? LG_W'(LG_TRK) : LG_W'(LG_ACQ);
      r_locked    <= (w_nxt == S_LOCKED);
      r_pll_in    <= w_nxt[1] ? adc_comp : 1'b0;
    end
  end

  assign state         = r_state;
  assign freq          = r_freq;
  assign load_freq     = r_load_freq;
  assign lgcoefficient = r_lg;
  assign pll_in        = r_pll_in;
  assign locked        = r_locked;
  assign reacq_cnt     = r_reacq;

endmodule
